// File: rtl/v_pkg.sv
// Shared definitions for the vector ALU arbiter: opcode constants, the
// sequencer state encoding and the divide-op classifier.
package v_pkg;

  localparam int VALU_OP_W = 5;

  localparam logic [VALU_OP_W-1:0] VALU_OP_NOP    = 5'd0;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VAND   = 5'd1;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VADD16 = 5'd2;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VDIV16 = 5'd3;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VSUB16 = 5'd4;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VOR    = 5'd5;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VADD32 = 5'd6;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VDIV32 = 5'd7;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VMUL16 = 5'd8;
  localparam logic [VALU_OP_W-1:0] VALU_OP_VMUL32 = 5'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Divides are the only multicycle ALU paths; the argument is widened so
  // callers with any opcode width can use it.
  function automatic logic is_div(input logic [31:0] op);
    return (op == 32'(VALU_OP_VDIV16)) || (op == 32'(VALU_OP_VDIV32));
  endfunction

endpackage

// File: rtl/v_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins a
// tie; a lone valid requester always wins.
module v_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // One-hot grant and its index, zero grant when nobody is requesting.
  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (valid == 2'b11) begin
      grant_idx = ptr;
      grant     = ptr ? 2'b10 : 2'b01;
    end else if (valid[1]) begin
      grant_idx = 1'b1;
      grant     = 2'b10;
    end else if (valid[0]) begin
      grant_idx = 1'b0;
      grant     = 2'b01;
    end
  end

endmodule

// File: rtl/v_alu_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared combinational
// vector ALU. One op in flight; operands are registered and held for one
// cycle (DIV_LAT cycles for divides, which are multicycle paths).
//
//   state | meaning
//   IDLE  | no op in flight, grant offered to requesters
//   EXEC  | ALU driven from registered operands, hold counter running
//   RESP  | result captured, response offered to the owning requester
module v_alu_arbiter
  import v_pkg::*;
#(
  parameter int VALUOP_DW = 5,
  parameter int VREG_DW   = 512,
  parameter int DIV_LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [2*VALUOP_DW-1:0] req_opcode_i,
  input  logic [2*VREG_DW-1:0]   req_v1_i,
  input  logic [2*VREG_DW-1:0]   req_v2_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [VREG_DW-1:0]     rsp_result_o,
  output logic                   busy_o,
  output logic [VALUOP_DW-1:0]   alu_opcode_o,
  output logic [VREG_DW-1:0]     alu_v1_o,
  output logic [VREG_DW-1:0]     alu_v2_o,
  input  logic [VREG_DW-1:0]     alu_result_i
);

  localparam int CNT_W = ($clog2(DIV_LAT + 1) < 1) ? 1 : $clog2(DIV_LAT + 1);

  arb_state_t state_q, state_d;

  logic                 ptr_q;
  logic                 owner_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [VALUOP_DW-1:0] op_q;
  logic [VREG_DW-1:0]   v1_q;
  logic [VREG_DW-1:0]   v2_q;
  logic [VREG_DW-1:0]   result_q;

  logic [1:0]           grant;
  logic                 grant_idx;
  logic                 accept;
  logic                 cnt_zero;
  logic                 rsp_done;
  logic [VALUOP_DW-1:0] sel_op;
  logic [VREG_DW-1:0]   sel_v1;
  logic [VREG_DW-1:0]   sel_v2;

  v_rr_arb2 u_rr_arb2 (
    .valid     (req_valid_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_op = grant_idx ? req_opcode_i[2*VALUOP_DW-1:VALUOP_DW] : req_opcode_i[VALUOP_DW-1:0];
  assign sel_v1 = grant_idx ? req_v1_i[2*VREG_DW-1:VREG_DW] : req_v1_i[VREG_DW-1:0];
  assign sel_v2 = grant_idx ? req_v2_i[2*VREG_DW-1:VREG_DW] : req_v2_i[VREG_DW-1:0];

  assign accept   = (state_q == ST_IDLE) && (grant != 2'b00);
  assign cnt_zero = (cnt_q == '0);
  assign rsp_done = (state_q == ST_RESP) && rsp_ready_i[owner_q];

  // Operands stay registered after the op, so the ALU inputs only toggle
  // when a new op is accepted.
  assign alu_v1_o     = v1_q;
  assign alu_v2_o     = v2_q;
  assign rsp_result_o = result_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and handshake/ALU control outputs.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 2'b00;
    rsp_valid_o  = 2'b00;
    alu_opcode_o = '0;
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = grant;
        if (grant != 2'b00) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_opcode_o = op_q;
        if (cnt_zero) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = owner_q ? 2'b10 : 2'b01;
        if (rsp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept, hold down-counter, result capture at terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= sel_op;
        v1_q    <= sel_v1;
        v2_q    <= sel_v2;
        owner_q <= grant_idx;
        cnt_q   <= is_div(32'(sel_op)) ? CNT_W'(DIV_LAT - 1) : '0;
      end else if ((state_q == ST_EXEC) && !cnt_zero) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if ((state_q == ST_EXEC) && cnt_zero) result_q <= alu_result_i;
    end
  end

  // Priority flips to the other requester after every completed response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ptr_q <= 1'b0;
    else if (rsp_done) ptr_q <= ~owner_q;
  end

endmodule

// File: tb/tb_v_alu_arbiter.sv
// Self-checking bench for v_alu_arbiter with a behavioural ALU stub and a
// transaction-level model compared against the DUT every cycle.
module tb_v_alu_arbiter;

  localparam int OPW     = 5;
  localparam int DW      = 512;
  localparam int DIV_LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready_o;
  logic [2*OPW-1:0]  req_opcode = '0;
  logic [2*DW-1:0]   req_v1 = '0;
  logic [2*DW-1:0]   req_v2 = '0;
  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready = 2'b11;
  logic [DW-1:0]     rsp_result_o;
  logic              busy_o;
  logic [OPW-1:0]    alu_opcode_o;
  logic [DW-1:0]     alu_v1_o;
  logic [DW-1:0]     alu_v2_o;
  logic [DW-1:0]     alu_result;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  v_alu_arbiter #(.VALUOP_DW(OPW), .VREG_DW(DW), .DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_opcode_i (req_opcode),
    .req_v1_i     (req_v1),
    .req_v2_i     (req_v2),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o),
    .alu_opcode_o (alu_opcode_o),
    .alu_v1_o     (alu_v1_o),
    .alu_v2_o     (alu_v2_o),
    .alu_result_i (alu_result)
  );

  // Stand-in for v_execute: lane-wise add/divide, everything else returns 0.
  function automatic logic [DW-1:0] alu_ref(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      5'd2: for (int i = 0; i < DW/16; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
      5'd6: for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
      5'd3: for (int i = 0; i < DW/16; i++)
              r[i*16 +: 16] = (a[i*16 +: 16] == 16'd0) ? 16'd0 : b[i*16 +: 16] / a[i*16 +: 16];
      5'd7: for (int i = 0; i < DW/32; i++)
              r[i*32 +: 32] = (a[i*32 +: 32] == 32'd0) ? 32'd0 : b[i*32 +: 32] / a[i*32 +: 32];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_result = alu_ref(alu_opcode_o, alu_v1_o, alu_v2_o);

  function automatic logic [DW-1:0] lanes16(input logic [15:0] x);
    return {(DW/16){x}};
  endfunction

  function automatic logic [DW-1:0] lanes32(input logic [31:0] x);
    return {(DW/32){x}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight, a hold time in ALU cycles,
  // then a response that waits for the owner's ready.
  int             m_busy = 0, m_ptr = 0, m_owner = 0, m_left = 0;
  logic [OPW-1:0] m_op = '0;
  logic [DW-1:0]  m_v1 = '0, m_v2 = '0, m_res = '0;

  always @(negedge clk) begin : model_chk
    logic [1:0]     e_rdy, e_rv;
    logic [OPW-1:0] e_op;
    int             w;
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_left = 0;
      m_op = '0; m_v1 = '0; m_v2 = '0; m_res = '0;
    end
    e_rdy = 2'b00;
    w = 0;
    if (rst && m_busy == 0 && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? m_ptr : (req_valid[1] ? 1 : 0);
      e_rdy = 2'b01 << w;
    end
    e_op = (m_busy != 0 && m_left > 0) ? m_op : '0;
    e_rv = (m_busy != 0 && m_left == 0) ? (2'b01 << m_owner) : 2'b00;
    check("m_req_ready", DW'(req_ready_o), DW'(e_rdy));
    check("m_rsp_valid", DW'(rsp_valid_o), DW'(e_rv));
    check("m_busy", DW'(busy_o), DW'(m_busy != 0));
    check("m_alu_opcode", DW'(alu_opcode_o), DW'(e_op));
    check("m_alu_v1", alu_v1_o, m_v1);
    check("m_alu_v2", alu_v2_o, m_v2);
    check("m_rsp_result", rsp_result_o, m_res);
    if (rst) begin
      if (m_busy == 0) begin
        if (e_rdy != 2'b00) begin
          m_busy  = 1;
          m_owner = w;
          m_op    = req_opcode[w*OPW +: OPW];
          m_v1    = req_v1[w*DW +: DW];
          m_v2    = req_v2[w*DW +: DW];
          m_left  = (m_op == 5'd3 || m_op == 5'd7) ? DIV_LAT : 1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_res = alu_ref(m_op, m_v1, m_v2);
      end else if (rsp_ready[m_owner]) begin
        m_busy = 0;
        m_ptr  = 1 - m_owner;
      end
    end
  end

  // Present a request on slot k and wait (bounded) for it to be accepted.
  // Called and returns at posedge+1.
  task automatic issue(input int k, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int acc_cyc, output logic [1:0] rdy_seen);
    req_opcode[k*OPW +: OPW] = op;
    req_v1[k*DW +: DW] = a;
    req_v2[k*DW +: DW] = b;
    req_valid[k] = 1'b1;
    acc_cyc = -1;
    rdy_seen = 2'b00;
    for (int i = 0; i < 40 && acc_cyc < 0; i++) begin
      @(negedge clk);
      if (req_ready_o[k]) begin
        rdy_seen = req_ready_o;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid[k] = 1'b0;
      end
    end
    if (acc_cyc < 0) begin
      check("accept_timeout", DW'(0), DW'(1));
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
    end
  endtask

  // Wait (bounded) for the response; counts cycles the ALU saw op before it.
  task automatic wait_rsp(input int k, input logic [OPW-1:0] op, output int rsp_cyc, output int hold,
                          output logic [DW-1:0] res);
    rsp_cyc = -1;
    hold = 0;
    res = '0;
    for (int i = 0; i < 40 && rsp_cyc < 0; i++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00) begin
        rsp_cyc = cyc;
        res = rsp_result_o;
        check("rsp_owner", DW'(rsp_valid_o), DW'(2'b01 << k));
      end else if (alu_opcode_o == op) begin
        hold++;
      end
    end
    if (rsp_cyc < 0) check("rsp_timeout", DW'(0), DW'(1));
    @(posedge clk);
    #1;
  endtask

  // Both requesters held valid; n ops must alternate starting at 'first'.
  task automatic contend(input int n, input int first, input int lat0, input int lat1, input bit want_zero);
    int g, gc, r, rc;
    for (int i = 0; i < n; i++) begin
      g = -1; gc = 0; r = -1; rc = 0;
      for (int j = 0; j < 40 && g < 0; j++) begin
        @(negedge clk);
        if (req_ready_o != 2'b00) begin g = req_ready_o[1] ? 1 : 0; gc = cyc; end
      end
      for (int j = 0; j < 40 && r < 0 && g >= 0; j++) begin
        @(negedge clk);
        if (rsp_valid_o != 2'b00) begin
          r = rsp_valid_o[1] ? 1 : 0;
          rc = cyc;
          if (want_zero) check("nop_result", rsp_result_o, '0);
        end
      end
      check("rr_grant", DW'(g), DW'((first + i) % 2));
      check("rr_rsp_owner", DW'(r), DW'((first + i) % 2));
      check("rr_latency", DW'(rc - gc - 1), DW'(((first + i) % 2 == 0) ? lat0 : lat1));
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, hold;
    logic [1:0] rdy;
    logic [DW-1:0] res;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", DW'(req_ready_o), '0);
    check("rst_rsp_valid", DW'(rsp_valid_o), '0);
    check("rst_busy", DW'(busy_o), '0);
    check("rst_alu_opcode", DW'(alu_opcode_o), '0);
    check("rst_rsp_result", rsp_result_o, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single non-div op
    issue(0, 5'd2, lanes16(16'd3), lanes16(16'd5), acc, rdy);
    check("t1_ready", DW'(rdy), DW'(2'b01));
    wait_rsp(0, 5'd2, rc, hold, res);
    check("t1_latency", DW'(rc - acc), DW'(1));
    check("t1_hold", DW'(hold), DW'(1));
    check("t1_result", res, lanes16(16'd8));

    // Divide hold
    issue(1, 5'd7, lanes32(32'd7), lanes32(32'd100), acc, rdy);
    check("t2_ready", DW'(rdy), DW'(2'b10));
    wait_rsp(1, 5'd7, rc, hold, res);
    check("t2_latency", DW'(rc - acc), DW'(4));
    check("t2_hold", DW'(hold), DW'(4));
    check("t2_result", res, lanes32(32'd14));

    // Contention and fairness
    req_opcode = {5'd3, 5'd6};
    req_v1 = {lanes16(16'd4), lanes32(32'h0001_0000)};
    req_v2 = {lanes16(16'd40), lanes32(32'h0000_0022)};
    req_valid = 2'b11;
    contend(4, 0, 1, 4, 1'b0);

    // Response backpressure, non-owner ready ignored, second request waits
    rsp_ready = 2'b10;
    issue(0, 5'd2, lanes16(16'h1234), lanes16(16'h0101), acc, rdy);
    req_opcode[OPW +: OPW] = 5'd6;
    req_v1[DW +: DW] = lanes32(32'd11);
    req_v2[DW +: DW] = lanes32(32'd22);
    req_valid[1] = 1'b1;
    rc = -1;
    for (int i = 0; i < 20 && rc < 0; i++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00) rc = cyc;
    end
    if (rc < 0) check("bp_timeout", DW'(0), DW'(1));
    check("bp_result", rsp_result_o, lanes16(16'h1335));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", DW'(rsp_valid_o), DW'(2'b01));
      check("bp_rsp_result", rsp_result_o, lanes16(16'h1335));
      check("bp_req_ready", DW'(req_ready_o), DW'(2'b00));
      check("bp_busy", DW'(busy_o), DW'(1));
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    issue(1, 5'd6, lanes32(32'd11), lanes32(32'd22), acc, rdy);
    wait_rsp(1, 5'd6, rc, hold, res);
    check("bp_next_result", res, lanes32(32'd33));

    // Reset in the middle of a divide
    issue(1, 5'd3, lanes16(16'd9), lanes16(16'd90), acc, rdy);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mr_req_ready", DW'(req_ready_o), '0);
    check("mr_rsp_valid", DW'(rsp_valid_o), '0);
    check("mr_busy", DW'(busy_o), '0);
    check("mr_alu_opcode", DW'(alu_opcode_o), '0);
    check("mr_alu_v1", alu_v1_o, '0);
    check("mr_rsp_result", rsp_result_o, '0);
    @(posedge clk);
    #1;
    req_opcode[OPW +: OPW] = 5'd2;
    req_v1[DW +: DW] = lanes16(16'd1);
    req_v2[DW +: DW] = lanes16(16'd1);
    req_valid[1] = 1'b1;
    rst = 1'b1;
    issue(0, 5'd2, lanes16(16'd20), lanes16(16'd22), acc, rdy);
    req_valid[1] = 1'b0;
    check("mr_ready_after", DW'(rdy), DW'(2'b01));
    wait_rsp(0, 5'd2, rc, hold, res);
    check("mr_result", res, lanes16(16'd42));

    // NOP and undefined opcode: pointer now favours requester 1
    req_opcode = {5'd31, 5'd0};
    req_v1 = {lanes16(16'd7), lanes16(16'd5)};
    req_v2 = {lanes16(16'd9), lanes16(16'd6)};
    req_valid = 2'b11;
    contend(2, 1, 1, 1, 1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/v_alu_arbiter.md
Name: v_alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared combinational vector ALU (v_execute).
- Accepts one vector op at a time over a valid/ready handshake and drives the ALU from registered operands.
- Holds the ALU inputs stable for 1 cycle, or DIV_LAT cycles for divide ops, which are constrained as multicycle paths.
- Captures the ALU result and returns it to the owning requester over a valid/ready response handshake.
- Sits between the vector issue stage (requester 0), the vector post-processing engine (requester 1) and v_execute.

Parameters:
VALUOP_DW, 5, opcode width (matches v_execute).
VREG_DW, 512, vector register / operand width.
DIV_LAT, 4, cycles ALU inputs are held for VDIV16/VDIV32; legal range >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid_i  in  2  per-requester request valid
req_ready_o  out  2  per-requester request accept
req_opcode_i  in  2*VALUOP_DW  opcode; requester k in slice [k*VALUOP_DW +: VALUOP_DW]
req_v1_i  in  2*VREG_DW  operand 1 per requester
req_v2_i  in  2*VREG_DW  operand 2 per requester
rsp_valid_o  out  2  response valid, one-hot, for the owning requester
rsp_ready_i  in  2  per-requester response accept
rsp_result_o  out  VREG_DW  shared response data bus
busy_o  out  1  high whenever state != IDLE
alu_opcode_o  out  VALUOP_DW  to v_execute valu_opcode_i
alu_v1_o  out  VREG_DW  to v_execute operand_v1_i
alu_v2_o  out  VREG_DW  to v_execute operand_v2_i
alu_result_i  in  VREG_DW  from v_execute valu_result_o

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: req_ready_o, rsp_valid_o, rsp_result_o, busy_o, alu_* are all 0.
  - State = IDLE, priority pointer = 0, counter = 0, owner = 0.
- Reset mid-operation: the in-flight op and any pending response are dropped silently. No response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from req_valid_i and the pointer.
  - If only one requester is valid, it wins. If both are valid, the requester equal to the pointer wins.
  - req_ready_o = grant vector in IDLE, 0 in all other states. At most one bit is set.
  - On the accept edge (valid & ready):
    - Register opcode, v1 and v2 into op_q, v1_q and v2_q, and store the owner id.
    - Load counter = DIV_LAT-1 if the opcode is 3 or 7, else 0.
    - Transition to EXEC.
- EXEC:
  - alu_opcode_o = op_q. alu_v1_o = v1_q and alu_v2_o = v2_q.
  - While counter != 0, decrement it.
  - When counter == 0, capture alu_result_i into rsp_result_o and go to RESP.
- Outside EXEC:
  - alu_opcode_o = 0 (NOP).
  - alu_v1_o and alu_v2_o keep their last registered values.
- RESP:
  - rsp_valid_o[owner] = 1. rsp_result_o is stable.
  - On rsp_ready_i[owner]: go to IDLE and set pointer = ~owner.
  - rsp_ready_i from the non-owner is ignored.
  - A request arriving during RESP waits; it is not accepted in the same cycle the response completes.
- Latency from the accept edge N:
  - Non-div op: rsp_valid rises after edge N+1.
  - Div op: rsp_valid rises after edge N+DIV_LAT.
  - Minimum per-op occupancy is latency + 1 IDLE cycle + response handshake.
- Opcode handling:
  - Opcodes are passed through unmodified.
  - NOP and undefined opcodes take the 1-cycle path; their result is whatever v_execute returns (0).
- Widths:
  - Counter width is $clog2(DIV_LAT+1) with a minimum of 1 bit.
  - No arithmetic on data: operands and result are carried bit-exact.
- Fairness: after any completed response the other requester has priority. Neither requester can be starved while the other issues back-to-back.
- Request-side stability: req_opcode/v1/v2 must be stable while req_valid is high. The arbiter samples them only on the accept edge.

Decomposition:
- Shared package v_pkg holds:
  - VALU_OP_* opcode constants (NOP=0 … VMUL32=9).
  - The state encoding (IDLE, EXEC, RESP).
  - An is_div(opcode) function returning true for 3 or 7.
- One sub-module is natural: v_rr_arb2.
  - Combinational 2-way round-robin grant from a 2-bit valid vector and a 1-bit pointer.
  - Outputs a one-hot grant and the grant index.

Test Plan:
- Single non-div op: requester 0 issues VADD16 (2) with every v1 lane = 3 and v2 lane = 5 → req_ready_o[0]=1 in IDLE; alu_opcode_o=2 for exactly 1 cycle; rsp_valid_o=01 one edge after accept; every 16-bit result lane = 8.
- Divide hold: requester 1 issues VDIV32 (7) with v2 lanes = 100 and v1 lanes = 7, DIV_LAT=4 → alu_opcode_o=7 held for exactly 4 cycles; rsp_valid_o=10 after edge N+4; result lanes = 14.
- Contention and fairness: both requesters continuously valid from reset → grants alternate 0,1,0,1 over 4 ops; rsp_valid never asserts for the non-owner.
- Response backpressure: hold rsp_ready_i[0]=0 for 10 cycles after rsp_valid → rsp_valid_o and rsp_result_o stay stable; req_ready_o=00 throughout; busy_o=1.
- Reset mid-divide: deassert rst two cycles into a DIV_LAT=4 op → all outputs 0 immediately (asynchronously); after release, the next request is accepted from requester 0 and no stale response appears.
- NOP/undefined opcode: opcode 0 and opcode 31 → 1-cycle path; rsp_result_o = 0; pointer toggles normally.
